// File: rtl/vc4000_cart_pkg.sv
// Shared types and constants for the VC4000 cartridge loader.
package vc4000_cart_pkg;

    localparam int unsigned IOCTL_AW         = 25;
    localparam logic [7:0]  CART_IDX_DEFAULT = 8'd1;
    localparam logic [7:0]  OPEN_BUS         = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        HOLD
    } cart_state_e;

    typedef struct packed {
        logic [IOCTL_AW-1:0] addr;
        logic [7:0]          data;
    } wr_entry_t;

endpackage

// File: rtl/vc4000_cart_loader_if.sv
// hps_io ioctl download stream plus CPU cartridge read port.
interface vc4000_cart_loader_if #(
    parameter int unsigned ADDR_W = 13
);
    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;
    logic                cpu_rd;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [7:0]          cpu_rdata;
    logic                cpu_rvalid;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_rd, cpu_addr,
        input  ioctl_wait, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_rd, cpu_addr,
        output ioctl_wait, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/vc4000_cart_ram.sv
// Single-port 2**ADDR_W x 8 cartridge RAM, synchronous read with one cycle latency.
module vc4000_cart_ram #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/vc4000_cart_loader.sv
// Streams the cartridge download into cart RAM through a write FIFO and holds the CPU while loading.
// Optional image checksum enabled by defining VC4000_CART_CSUM_EN.
module vc4000_cart_loader
    import vc4000_cart_pkg::*;
#(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CART_IDX   = CART_IDX_DEFAULT,
    parameter int unsigned HOLD_CYC   = 16
) (
    input  logic              clk,
    input  logic              reset,
    vc4000_cart_loader_if.slave bus,
    output logic [ADDR_W:0]   cart_size,
    output logic              cart_loaded,
    output logic              load_ovf,
    output logic              core_hold,
    output logic [15:0]       cart_csum
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HC_W   = $clog2(HOLD_CYC + 1);
    localparam int unsigned SIZE_W = ADDR_W + 1;
    localparam int unsigned END_W  = IOCTL_AW + 1;

    cart_state_e       state, state_nxt;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic              sel, sel_q, rise, accept, push, drop, pop, flush_done;
    wr_entry_t         fifo_mem [FIFO_DEPTH];
    wr_entry_t         head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
    logic [END_W-1:0]  commit_end;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              open_bus_q;

    assign sel    = bus.ioctl_download && (bus.ioctl_index == CART_IDX);
    assign rise   = sel && !sel_q;
    assign accept = sel && bus.ioctl_wr && (state == LOAD || rise);
    assign push   = accept && ((bus.ioctl_addr >> ADDR_W) == '0);
    assign drop   = accept && ((bus.ioctl_addr >> ADDR_W) != '0);
    // CPU owns the RAM port whenever it reads; the FIFO drains in the gaps
    assign pop          = !bus.cpu_rd && (fifo_cnt != '0);
    assign head         = fifo_mem[rd_ptr];
    assign fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    assign commit_end   = END_W'(head.addr) + END_W'(1);
    assign ram_addr     = bus.cpu_rd ? bus.cpu_addr : head.addr[ADDR_W-1:0];

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        flush_done   = 1'b0;
        case (state)
            IDLE:  if (rise) state_nxt = LOAD;
            LOAD:  if (!sel) state_nxt = FLUSH;
            FLUSH: begin
                if (rise) begin
                    state_nxt = LOAD;
                end else if (fifo_cnt == '0) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HC_W'(1);
                    flush_done   = 1'b1;
                end
            end
            HOLD: begin
                if (rise)                                 state_nxt = LOAD;
                else if (hold_cnt == HC_W'(HOLD_CYC - 1)) state_nxt = IDLE;
                else                                      hold_cnt_nxt = hold_cnt + HC_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sel_q resets high so a download already running at reset release is ignored until it restarts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            sel_q     <= 1'b1;
            core_hold <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            sel_q     <= sel;
            core_hold <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            bus.ioctl_wait <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt       <= fifo_cnt_nxt;
            bus.ioctl_wait <= (fifo_cnt_nxt >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.ioctl_addr, bus.ioctl_dout};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_cnt == CNT_W'(FIFO_DEPTH)));

    // Image size / status, restarted on each new cartridge download
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cart_size   <= '0;
            cart_loaded <= 1'b0;
            load_ovf    <= 1'b0;
        end else if (rise) begin
            cart_size   <= '0;
            cart_loaded <= 1'b0;
            load_ovf    <= drop;
        end else begin
            if (pop && commit_end > END_W'(cart_size)) cart_size <= SIZE_W'(commit_end);
            if (flush_done) cart_loaded <= (cart_size != '0);
            if (drop)       load_ovf    <= 1'b1;
        end
    end

`ifdef VC4000_CART_CSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cart_csum <= '0;
        else if (rise) cart_csum <= '0;
        else if (pop)  cart_csum <= cart_csum + 16'(head.data);
    end
`else
    assign cart_csum = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_rvalid <= 1'b0;
            open_bus_q     <= 1'b0;
        end else begin
            bus.cpu_rvalid <= bus.cpu_rd;
            open_bus_q     <= bus.cpu_rd && (state == IDLE) && cart_loaded &&
                              (SIZE_W'(bus.cpu_addr) >= cart_size);
        end
    end

    assign bus.cpu_rdata = !bus.cpu_rvalid ? 8'h00 : (open_bus_q ? OPEN_BUS : ram_rdata);

    vc4000_cart_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (pop),
        .addr  (ram_addr),
        .wdata (head.data),
        .rdata (ram_rdata)
    );
endmodule
